stdp_weight_updater: RTL and testbench

//  Learning engine directly upstream of the per-neuron weight RAM. On a post-synaptic

---
 rtl/stdp_weight_updater_pkg.sv | 37 +++
 rtl/stdp_delta_clamp.sv | 26 ++
 rtl/stdp_weight_updater.sv | 151 +++++++++++++++
 tb/tb_stdp_weight_updater.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_weight_updater_pkg.sv
// Shared constants, state encoding and saturation helper for the STDP weight updater.
package stdp_weight_updater_pkg;

    localparam int M    = 784;
    localparam int AW   = 10;
    localparam int W    = 24;
    localparam int TW   = 16;
    localparam int TWIN = 20;

    localparam logic signed [W-1:0] WMAX    = 24'sd65536;
    localparam logic signed [W-1:0] WMIN    = -24'sd65536;
    localparam logic signed [W-1:0] A_PLUS  = 24'sd512;
    localparam logic signed [W-1:0] A_MINUS = 24'sd256;

    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Clamp a one-bit-wider sum into the legal weight range; never wraps.
    function automatic logic signed [W-1:0] sat_weight(input logic signed [W:0] sum);
        logic signed [W:0] hi;
        logic signed [W:0] lo;
        hi = WMAX;
        lo = WMIN;
        if (sum > hi)
            return WMAX;
        else if (sum < lo)
            return WMIN;
        else
            return sum[W-1:0];
    endfunction

endpackage

// File: rtl/stdp_delta_clamp.sv
// Combinational STDP update for one synapse: timing compare, step select, add, saturate.
module stdp_delta_clamp
    import stdp_weight_updater_pkg::*;
(
    input  logic signed [W-1:0]  weight,
    input  logic [TW-1:0]        t_post,
    input  logic [TW-1:0]        pre_t,
    input  logic                 pre_valid,
    output logic signed [W-1:0]  weight_new
);

    logic signed [TW:0]  dt;
    logic                potentiate;
    logic signed [W-1:0] delta;
    logic signed [W:0]   sum;

    // A pre spike later than the post spike gives dt<0 and therefore depresses.
    always_comb begin
        dt         = $signed({1'b0, t_post}) - $signed({1'b0, pre_t});
        potentiate = pre_valid && !dt[TW] && (dt <= (TW+1)'(TWIN));
        delta      = potentiate ? A_PLUS : -A_MINUS;
        sum        = (W+1)'(weight) + (W+1)'(delta);
        weight_new = sat_weight(sum);
    end

endmodule

// File: rtl/stdp_weight_updater.sv
// STDP learning engine: on an accepted post spike, sweeps all synapses through a
// 3-stage read / compute / write-back pipeline, one synapse per clock.
//
//  state | meaning
//  IDLE  | waiting for start; tracks t_post so it is captured with start
//  SWEEP | issuing read addresses 0..M-1, one per cycle
//  DRAIN | two cycles letting the last reads reach write-back
module stdp_weight_updater
    import stdp_weight_updater_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 learn_en,
    input  logic [TW-1:0]        t_post,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        addr_r,
    input  logic signed [W-1:0]  data_r,
    output logic [AW-1:0]        pre_addr,
    input  logic [TW-1:0]        pre_t,
    input  logic                 pre_valid,
    output logic                 we,
    output logic [AW-1:0]        addr_w,
    output logic signed [W-1:0]  data_w
);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic [AW-1:0]       rd_cnt;
    logic                drain_cnt;
    logic [TW-1:0]       tpost_q;
    logic                iss_vld;
    logic                s1_vld;
    logic [AW-1:0]       s1_addr;
    logic signed [W-1:0] weight_new;
    logic                last_write;

    assign last_write = we && (addr_w == LAST_ADDR);

    // Next-state decode; busy also blocks start during the final write-back cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start && learn_en && !busy;
                if (accept)
                    state_nxt = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (rd_cnt == LAST_ADDR)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == 1'b0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, read counter, drain timer and post-spike time capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            drain_cnt <= 1'b0;
            tpost_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    tpost_q <= t_post;
                    rd_cnt  <= '0;
                end
                ST_SWEEP: begin
                    rd_cnt    <= rd_cnt + 1'b1;
                    drain_cnt <= 1'b1;
                end
                ST_DRAIN: drain_cnt <= drain_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // S0: issue read addresses to both RAMs; addresses hold outside SWEEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_vld  <= 1'b0;
            addr_r   <= '0;
            pre_addr <= '0;
        end else begin
            iss_vld <= (state == ST_SWEEP);
            if (state == ST_SWEEP) begin
                addr_r   <= rd_cnt;
                pre_addr <= rd_cnt;
            end
        end
    end

    // S1: RAM data is valid this cycle; track which synapse it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_vld  <= iss_vld;
            s1_addr <= addr_r;
        end
    end

    stdp_delta_clamp u_delta_clamp (
        .weight     (data_r),
        .t_post     (tpost_q),
        .pre_t      (pre_t),
        .pre_valid  (pre_valid),
        .weight_new (weight_new)
    );

    // S2: registered write-back of the updated weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we     <= 1'b0;
            addr_w <= '0;
            data_w <= '0;
        end else begin
            we <= s1_vld;
            if (s1_vld) begin
                addr_w <= s1_addr;
                data_w <= weight_new;
            end
        end
    end

    // busy spans accept to the final write; done follows that write by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last_write;
            if (accept)
                busy <= 1'b1;
            else if (last_write)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stdp_weight_updater.sv
// Self-checking bench for stdp_weight_updater with behavioural weight and pre-time RAMs.
module tb_stdp_weight_updater;
    import stdp_weight_updater_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                learn_en;
    logic [TW-1:0]       t_post;
    logic                busy;
    logic                done;
    logic [AW-1:0]       addr_r;
    logic signed [W-1:0] data_r;
    logic [AW-1:0]       pre_addr;
    logic [TW-1:0]       pre_t;
    logic                pre_valid;
    logic                we;
    logic [AW-1:0]       addr_w;
    logic signed [W-1:0] data_w;

    stdp_weight_updater dut (
        .clk(clk), .rst(rst), .start(start), .learn_en(learn_en), .t_post(t_post),
        .busy(busy), .done(done), .addr_r(addr_r), .data_r(data_r),
        .pre_addr(pre_addr), .pre_t(pre_t), .pre_valid(pre_valid),
        .we(we), .addr_w(addr_w), .data_w(data_w)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] wmem  [M];
    logic signed [W-1:0] winit [M];
    logic [TW-1:0]       tmem  [M];
    logic                vmem  [M];
    logic                ld = 1'b0;

    // Synchronous RAMs: one-cycle read latency, write on we, bulk load on ld.
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < M; i++) wmem[i] <= winit[i];
        end else if (we) begin
            wmem[addr_w] <= data_w;
        end
        data_r    <= wmem[addr_r];
        pre_t     <= tmem[pre_addr];
        pre_valid <= vmem[pre_addr];
    end

    typedef struct {
        logic [AW-1:0]       addr;
        logic signed [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c_start = 0;
    int wr_cnt, done_cnt, done_cyc, first_we, last_we;

    function automatic logic signed [W-1:0] model_weight(int w, int tp, int pt, logic pv);
        int dt;
        int s;
        dt = tp - pt;
        s = (pv && dt >= 0 && dt <= 20) ? w + 512 : w - 256;
        if (s > 65536) s = 65536;
        if (s < -65536) s = -65536;
        return W'(s);
    endfunction

    task automatic clear_counts();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_we = -1; last_we = -1;
    endtask

    // Advance one cycle, sample at the falling edge and retire scoreboard entries.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (we) begin
                wr_cnt++;
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra_write got addr=%0d data=%0d required none", addr_w, data_w);
                end else begin
                    e = exp_q.pop_front();
                    if (addr_w !== e.addr || data_w !== e.data) begin
                        bad++;
                        $display("FAIL sb_write got addr=%0d data=%0d required addr=%0d data=%0d",
                                 addr_w, data_w, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic load_weights();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic start_sweep(input logic [TW-1:0] tp);
        exp_t e;
        for (int k = 0; k < M; k++) begin
            e.addr = AW'(k);
            e.data = model_weight(int'(wmem[k]), int'(tp), int'(tmem[k]), vmem[k]);
            exp_q.push_back(e);
        end
        t_post = tp; learn_en = 1'b1; start = 1'b1;
        tick();
        c_start = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int n0;
        n0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (done_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; learn_en = 1'b0; t_post = '0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b required=0", done); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b required=0", we); end
        total++; if (addr_r !== '0 || pre_addr !== '0 || addr_w !== '0) begin
            bad++; $display("FAIL rst_addr got r=%0d p=%0d w=%0d required 0", addr_r, pre_addr, addr_w);
        end
        total++; if (data_w !== '0) begin bad++; $display("FAIL rst_data_w got=%0d required=0", data_w); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_potentiation();
        bit ok;
        for (int k = 0; k < M; k++) begin winit[k] = '0; tmem[k] = 16'd40; vmem[k] = 1'b1; end
        load_weights();
        clear_counts();
        start_sweep(16'd50);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pot_busy got=%0b required=1", busy); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL pot_timeout got=no_done required=done"); end
        total++; if (wr_cnt !== M) begin bad++; $display("FAIL pot_writes got=%0d required=%0d", wr_cnt, M); end
        total++; if (first_we !== c_start + 3) begin bad++; $display("FAIL pot_first_we got=%0d required=%0d", first_we, c_start + 3); end
        total++; if (last_we !== c_start + M + 2) begin bad++; $display("FAIL pot_last_we got=%0d required=%0d", last_we, c_start + M + 2); end
        total++; if (done_cyc !== c_start + M + 3) begin bad++; $display("FAIL pot_done_cyc got=%0d required=%0d", done_cyc, c_start + M + 3); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pot_busy_end got=%0b required=0", busy); end
        total++; if (wmem[0] !== 24'sd512 || wmem[M-1] !== 24'sd512) begin
            bad++; $display("FAIL pot_mem got w0=%0d wlast=%0d required 512", wmem[0], wmem[M-1]);
        end
        tick();
    endtask

    task automatic test_depression();
        bit ok;
        for (int k = 0; k < M; k++) begin winit[k] = 24'sd1000; tmem[k] = 16'd40; vmem[k] = 1'b0; end
        load_weights();
        start_sweep(16'd50);
        wait_done(ok);
        total++; if (!ok || wmem[5] !== 24'sd744) begin bad++; $display("FAIL dep_invalid got=%0d required=744", wmem[5]); end
        for (int k = 0; k < M; k++) begin tmem[k] = 16'd70; vmem[k] = 1'b1; end
        load_weights();
        start_sweep(16'd50);
        wait_done(ok);
        total++; if (!ok || wmem[M-1] !== 24'sd744) begin bad++; $display("FAIL dep_late_pre got=%0d required=744", wmem[M-1]); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dep_queue got=%0d required=0", exp_q.size()); end
        tick();
    endtask

    task automatic test_saturation();
        bit ok;
        for (int k = 0; k < M; k++) begin
            winit[k] = W'(int'($urandom_range(0, 131072)) - 65536);
            tmem[k]  = TW'(950 + $urandom_range(0, 100));
            vmem[k]  = ($urandom_range(0, 3) != 0);
        end
        winit[0] = 24'sd65300;  tmem[0] = 16'd990;  vmem[0] = 1'b1;
        winit[1] = -24'sd65400; tmem[1] = 16'd1010; vmem[1] = 1'b1;
        winit[2] = 24'sd65536;  tmem[2] = 16'd1000; vmem[2] = 1'b1;
        winit[3] = -24'sd65536; tmem[3] = 16'd900;  vmem[3] = 1'b1;
        load_weights();
        start_sweep(16'd1000);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=no_done required=done"); end
        total++; if (wmem[0] !== 24'sd65536) begin bad++; $display("FAIL sat_hi got=%0d required=65536", wmem[0]); end
        total++; if (wmem[1] !== -24'sd65536) begin bad++; $display("FAIL sat_lo got=%0d required=-65536", wmem[1]); end
        total++; if (wmem[2] !== 24'sd65536) begin bad++; $display("FAIL sat_hold_hi got=%0d required=65536", wmem[2]); end
        total++; if (wmem[3] !== -24'sd65536) begin bad++; $display("FAIL sat_hold_lo got=%0d required=-65536", wmem[3]); end
        tick();
    endtask

    task automatic test_window();
        bit ok;
        for (int k = 0; k < M; k++) begin winit[k] = '0; tmem[k] = '0; vmem[k] = 1'b1; end
        tmem[0] = 16'd80; tmem[1] = 16'd79; tmem[2] = 16'd100; tmem[3] = 16'd101; tmem[4] = 16'hFFFF;
        load_weights();
        start_sweep(16'd100);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL win_timeout got=no_done required=done"); end
        total++; if (wmem[0] !== 24'sd512) begin bad++; $display("FAIL win_dt20 got=%0d required=512", wmem[0]); end
        total++; if (wmem[1] !== -24'sd256) begin bad++; $display("FAIL win_dt21 got=%0d required=-256", wmem[1]); end
        total++; if (wmem[2] !== 24'sd512) begin bad++; $display("FAIL win_dt0 got=%0d required=512", wmem[2]); end
        total++; if (wmem[3] !== -24'sd256 || wmem[4] !== -24'sd256) begin
            bad++; $display("FAIL win_neg got=%0d,%0d required=-256", wmem[3], wmem[4]);
        end
        tick();
    endtask

    task automatic test_ignored();
        bit ok;
        clear_counts();
        t_post = 16'd50; learn_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; learn_en = 1'b1;
        repeat (5) tick();
        total++; if (busy !== 1'b0 || wr_cnt != 0 || done_cnt != 0) begin
            bad++; $display("FAIL ign_learn_off got busy=%0b writes=%0d dones=%0d required 0", busy, wr_cnt, done_cnt);
        end
        start_sweep(16'd50);
        repeat (100) tick();
        t_post = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ok);
        repeat (10) tick();
        total++; if (!ok || done_cnt != 1) begin bad++; $display("FAIL ign_busy_dones got=%0d required=1", done_cnt); end
        total++; if (wr_cnt != M) begin bad++; $display("FAIL ign_busy_writes got=%0d required=%0d", wr_cnt, M); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_counts();
        start_sweep(16'd45);
        wait_done(ok);
        start_sweep(16'd60);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%0b required=1", busy); end
        wait_done(ok);
        total++; if (!ok || done_cyc !== c_start + M + 3) begin
            bad++; $display("FAIL b2b_done_cyc got=%0d required=%0d", done_cyc, c_start + M + 3);
        end
        total++; if (done_cnt != 2 || wr_cnt != 2 * M) begin
            bad++; $display("FAIL b2b_counts got dones=%0d writes=%0d required 2,%0d", done_cnt, wr_cnt, 2 * M);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        int n_old;
        int n_new;
        for (int k = 0; k < M; k++) begin winit[k] = 24'sd7; tmem[k] = 16'd40; vmem[k] = 1'b1; end
        load_weights();
        clear_counts();
        start_sweep(16'd50);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (we && addr_w == AW'(100)) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_reach got=no_k100 required=k100"); end
        #1 rst = 1'b1;
        #1;
        total++; if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rmid_async got we=%0b busy=%0b done=%0b required 0", we, busy, done);
        end
        total++; if (addr_r !== '0 || addr_w !== '0 || data_w !== '0) begin
            bad++; $display("FAIL rmid_regs got r=%0d w=%0d d=%0d required 0", addr_r, addr_w, data_w);
        end
        repeat (3) tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (20) tick();
        total++; if (done_cnt != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_no_done got dones=%0d busy=%0b required 0", done_cnt, busy);
        end
        n_old = 0; n_new = 0;
        for (int k = 0; k < 100; k++) if (wmem[k] !== 24'sd519) n_new++;
        for (int k = 101; k < M; k++) if (wmem[k] !== 24'sd7) n_old++;
        total++; if (n_new != 0) begin bad++; $display("FAIL rmid_written got_bad=%0d required=0", n_new); end
        total++; if (n_old != 0) begin bad++; $display("FAIL rmid_untouched got_bad=%0d required=0", n_old); end
    endtask

    initial begin
        test_reset();
        test_potentiation();
        test_depression();
        test_saturation();
        test_window();
        test_ignored();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
